// File: rtl/minimig_autoconfig_ctrl.sv
// Zorro autoconfig sequencer: walks the board chain, serves ROM nybbles to the CPU and
// latches base addresses / shut-up requests written into config space.
module minimig_autoconfig_ctrl #(
  parameter int unsigned        NBOARDS   = 7,
  parameter logic [NBOARDS-1:0] ZIII_MASK = 7'b0011110
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NBOARDS-1:0]     board_en,
  input  logic                   sel,
  input  logic                   rd,
  input  logic                   wr,
  input  logic [5:0]             addr,
  input  logic [15:0]            din,
  output logic [15:0]            dout,
  output logic                   ack,
  output logic [8:0]             rom_a,
  input  logic [3:0]             rom_q,
  output logic [16*NBOARDS-1:0]  bases,
  output logic [NBOARDS-1:0]     board_cfg,
  output logic [NBOARDS-1:0]     board_shut,
  output logic                   config_done
);

  localparam logic [2:0] IdxNull    = 3'd7;
  localparam logic [5:0] OffZ3Base  = 6'h22;
  localparam logic [5:0] OffZ2Base  = 6'h24;
  localparam logic [5:0] OffShutUp  = 6'h26;

  typedef enum logic [2:0] {
    StIdle,
    StRdA,
    StRdW,
    StRdD,
    StWrAck
  } state_e;

  state_e                       state_q, state_d;
  logic [2:0]                   idx_q, idx_d;
  logic [8:0]                   rom_a_q, rom_a_d;
  logic [15:0]                  dout_q, dout_d;
  logic                         ack_q, ack_d;
  logic [NBOARDS-1:0][15:0]     bases_q, bases_d;
  logic [NBOARDS-1:0]           cfg_q, cfg_d;
  logic [NBOARDS-1:0]           shut_q, shut_d;
  logic                         advance;
  logic                         is_z3;

  // Lowest enabled board index, or the null terminator when nothing is enabled.
  function automatic logic [2:0] first_en(input logic [NBOARDS-1:0] en);
    logic [2:0] res;
    res = IdxNull;
    for (int i = NBOARDS - 1; i >= 0; i--) begin
      if (en[i]) res = 3'(i);
    end
    return res;
  endfunction

  function automatic logic [2:0] next_en(input logic [NBOARDS-1:0] en, input logic [2:0] cur);
    logic [2:0] res;
    res = IdxNull;
    for (int i = NBOARDS - 1; i >= 0; i--) begin
      if (en[i] && (i > int'(cur))) res = 3'(i);
    end
    return res;
  endfunction

  assign is_z3 = (idx_q != IdxNull) && ZIII_MASK[idx_q];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rom_a_d = rom_a_q;
    dout_d  = dout_q;
    ack_d   = 1'b0;
    bases_d = bases_q;
    cfg_d   = cfg_q;
    shut_d  = shut_q;
    advance = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (sel && wr) begin
          state_d = StWrAck;
          // The null terminator has no registers: writes are acknowledged only.
          if (idx_q != IdxNull) begin
            case (addr)
              OffZ3Base: begin
                if (is_z3) begin
                  bases_d[idx_q] = din;
                  cfg_d[idx_q]   = 1'b1;
                  advance        = 1'b1;
                end
              end
              OffZ2Base: begin
                if (is_z3) begin
                  bases_d[idx_q][7:0] = din[15:8];
                end else begin
                  bases_d[idx_q] = {8'h00, din[15:8]};
                  cfg_d[idx_q]   = 1'b1;
                  advance        = 1'b1;
                end
              end
              OffShutUp: begin
                shut_d[idx_q] = 1'b1;
                advance       = 1'b1;
              end
              default: ;
            endcase
          end
        end else if (sel && rd) begin
          state_d = StRdA;
          rom_a_d = {idx_q, addr};
        end
      end
      StRdA:   state_d = StRdW;
      StRdW:   state_d = StRdD;
      StRdD: begin
        dout_d  = {rom_q, 12'hFFF};
        ack_d   = 1'b1;
        state_d = StIdle;
      end
      StWrAck: begin
        ack_d   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (advance) idx_d = next_en(board_en, idx_q);
  end

  // The starting board is taken from board_en while reset is held, so the chain
  // position is valid (and config_done meaningful) from the first cycle after release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= first_en(board_en);
      rom_a_q <= {first_en(board_en), 6'h00};
      dout_q  <= 16'hFFFF;
      ack_q   <= 1'b0;
      bases_q <= '0;
      cfg_q   <= '0;
      shut_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rom_a_q <= rom_a_d;
      dout_q  <= dout_d;
      ack_q   <= ack_d;
      bases_q <= bases_d;
      cfg_q   <= cfg_d;
      shut_q  <= shut_d;
    end
  end

  assign dout        = dout_q;
  assign ack         = ack_q;
  assign rom_a       = rom_a_q;
  assign bases       = bases_q;
  assign board_cfg   = cfg_q;
  assign board_shut  = shut_q;
  assign config_done = (idx_q == IdxNull);

endmodule

// File: doc/minimig_autoconfig_ctrl.md
Name: minimig_autoconfig_ctrl

Overview:
- Autoconfig sequencer for the Zorro config space at $E80000.
- Consumes the 4-bit autoconfig ROM: drives its 9-bit read address as {board index[2:0], register offset[5:0]} and presents the returned nybble to the CPU bus.
- Walks the board chain in order, skipping disabled boards.
- Latches base addresses on CPU config writes, handles shut-up writes, and reports per-board configured/shut-up flags plus chain completion.

Parameters:
- NBOARDS, 7, number of real boards (indices 0..6); index 7 is the null terminator.
- ZIII_MASK, 7'b0011110, bit i set means board i is Zorro-III (base-write protocol at $44); clear means Zorro-II (base write at $48).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- board_en  in  7  per-board enable mask; bit i enables board i
- sel  in  1  CPU access decoded to config space; qualifies rd/wr
- rd  in  1  read request strobe, one cycle
- wr  in  1  write request strobe, one cycle
- addr  in  6  CPU address A6..A1
- din  in  16  CPU write data
- dout  out  16  read data: nybble on [15:12], [11:0] = 12'hFFF
- ack  out  1  one-cycle transfer acknowledge
- rom_a  out  9  ROM read address
- rom_q  in  4  ROM read data (2-cycle ROM latency)
- bases  out  112  board i base in bits [16i+15:16i], as A31..A16
- board_cfg  out  7  board configured
- board_shut  out  7  board shut up
- config_done  out  1  chain exhausted (index 7 active)

Behaviour:
- Reset values: dout=16'hFFFF, ack=0, bases=0, board_cfg=0, board_shut=0, rom_a={idx,6'h00}.
- On reset, idx = lowest set bit of board_en, or 7 if none; config_done=1 iff idx==7.
- States: IDLE, RD_A, RD_W, RD_D, WR_ACK.
- IDLE:
  - sel&wr → WR_ACK.
  - sel&rd → RD_A, registering rom_a={idx,addr}.
  - wr has priority if rd and wr are both asserted.
  - rd/wr without sel is ignored.
- Read path:
  - RD_A → RD_W → RD_D. ROM samples the address at the RD_A edge and q is valid at the RD_W edge.
  - RD_D registers dout={rom_q,12'hFFF}, pulses ack, returns to IDLE.
  - Request edge to ack-high latency: exactly 3 clocks.
  - rom_a is held stable from RD_A through RD_D. No inversion is applied; the ROM content is already encoded.
- Write path: WR_ACK pulses ack one clock after the request, then IDLE. dout is unchanged. Actions are applied at the request edge:
  - Z2 board, addr=$48>>1 (6'h24): bases[idx][7:0]=din[15:8], [15:8]=0; board_cfg[idx]=1; advance.
  - Z3 board, addr=6'h22 ($44): bases[idx]=din; board_cfg[idx]=1; advance.
  - Z3 board, addr=6'h24: bases[idx][7:0]=din[15:8]; no advance.
  - Any board, addr=6'h26 ($4C): board_shut[idx]=1, base untouched; advance.
  - Other offsets: ack only.
  - idx==7: all writes ack only.
- Advance: idx = lowest enabled index > idx, else 7.
- board_en is evaluated only at reset and at advance. Changes never move the current idx.
- rd/wr strobes arriving while not in IDLE are dropped, with no ack and no effect.
- Reset mid-transaction aborts immediately: no ack, all state returns to reset values.

Test Plan:
- board_en=7'h7F, read addr 6'h00 → ack 3 clocks after rd, rom_a=9'h000, dout=16'hEFFF. Read 6'h08 → rom_a=9'h008, dout=16'hEFFF.
- Write $48 din=16'h2000 on board 0 → ack next clock; bases[15:0]=16'h0020; board_cfg=7'h01; subsequent read addr 0 → rom_a=9'h040.
- Board 1 (Z3): write 6'h24 din=16'h4000 → no advance, bases[31:16]=16'h0040. Then write 6'h22 din=16'h4000 → bases[31:16]=16'h4000, board_cfg[1]=1, idx=2.
- board_en=7'b1010001: configure board 0 → idx=4. Write 6'h26 → board_shut=7'h10, idx=6. Configure board 6 → config_done=1. Reads → rom_a=9'h1C0+addr, dout=16'hFFFF.
- rd asserted in RD_W, and wr in RD_A → dropped: exactly one ack, no state change. rd&wr together in IDLE → treated as write.
- Reset asserted during RD_W → no ack; after release, with board_en=0, config_done=1, bases=0, board_cfg=0, board_shut=0.
